// File: rtl/instr_encoder.sv
// RV32 instruction-word assembler: check stage then output register, 2-cycle latency, 1 word/cycle.
// Stalls in_ready only when both stages hold words and out_ready is low; rejected requests never occupy the pipe.
module instr_encoder #(
  parameter int CNT_W       = 16,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instruction_word,
  output logic [2:0]       out_type,
  output logic             err,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] TY_R = 3'd0;
  localparam logic [2:0] TY_I = 3'd1;
  localparam logic [2:0] TY_S = 3'd2;
  localparam logic [2:0] TY_B = 3'd3;
  localparam logic [2:0] TY_U = 3'd4;
  localparam logic [2:0] TY_J = 3'd5;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_U = 7'b0110111;
  localparam logic [6:0] OP_J = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_rst_done;
  logic             r_s1_vld;
  logic [31:0]      r_s1_word;
  logic [2:0]       r_s1_type;
  logic             r_s2_vld;
  logic [31:0]      r_s2_word;
  logic [2:0]       r_s2_type;
  logic             r_err;
  logic [CNT_W-1:0] r_inst_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0]      w_word;
  logic             w_type_bad;
  logic             w_align_bad;
  logic             w_range_bad;
  logic             w_illegal;
  logic             w_fit12;
  logic             w_fit13;
  logic             w_fit21;
  logic             w_accept;
  logic             w_s2_free;
  logic             w_out_hs;

  // An immediate fits in N signed bits when all bits above N-1 replicate the sign.
  assign w_fit12 = (in_imm[31:11] == {21{in_imm[31]}});
  assign w_fit13 = (in_imm[31:12] == {20{in_imm[31]}});
  assign w_fit21 = (in_imm[31:20] == {12{in_imm[31]}});

  always_comb begin
    w_word      = '0;
    w_type_bad  = 1'b0;
    w_align_bad = 1'b0;
    w_range_bad = 1'b0;
    case (in_type)
      TY_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      TY_I: begin
        w_word      = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        w_range_bad = !w_fit12;
      end
      TY_S: begin
        w_word      = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
        w_range_bad = !w_fit12;
      end
      TY_B: begin
        w_word      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_B};
        w_align_bad = in_imm[0];
        w_range_bad = !w_fit13;
      end
      TY_U: begin
        w_word      = {in_imm[31:12], in_rd, OP_U};
        w_range_bad = (in_imm[11:0] != 12'd0);
      end
      TY_J: begin
        w_word      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
        w_align_bad = in_imm[0];
        w_range_bad = !w_fit21;
      end
      default: w_type_bad = 1'b1;
    endcase
  end

  assign w_illegal = w_type_bad | w_align_bad | (CHECK_RANGE & w_range_bad);

  // Stage 1 may refill in the same cycle it drains into stage 2.
  assign w_s2_free = !r_s2_vld | out_ready;
  assign w_out_hs  = r_s2_vld & out_ready;
  assign in_ready  = r_rst_done & (!r_s1_vld | w_s2_free);
  assign w_accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
      r_s1_type <= '0;
    end else if (w_accept && !w_illegal) begin
      r_s1_vld  <= 1'b1;
      r_s1_word <= w_word;
      r_s1_type <= in_type;
    end else if (w_s2_free) begin
      r_s1_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_word <= '0;
      r_s2_type <= '0;
    end else if (w_s2_free) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_word <= r_s1_word;
        r_s2_type <= r_s1_type;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_inst_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_err <= w_accept & w_illegal;
      if (w_out_hs && (r_inst_cnt != {CNT_W{1'b1}})) begin
        r_inst_cnt <= r_inst_cnt + CNT_ONE;
      end
      if (w_accept && w_illegal && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end
    end
  end

  assign out_valid        = r_s2_vld;
  assign instruction_word = r_s2_word;
  assign out_type         = r_s2_type;
  assign err              = r_err;
  assign inst_count       = r_inst_cnt;
  assign err_count        = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32 words, rejects, back-pressure and mid-run reset.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction_word;
  logic [2:0]  out_type;
  logic        err;
  logic [15:0] inst_count;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_inst = 0;
  int exp_err  = 0;

  instr_encoder #(.CNT_W(16), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_word(instruction_word), .out_type(out_type),
    .err(err), .inst_count(inst_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Returns at the falling edge one cycle after the accepting edge.
  task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    int n;
    drive(t, rd, rs1, rs2, f3, f7, imm);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] word, input logic [2:0] ty);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"}, instruction_word, word);
    chk({tag, "_type"}, 32'(out_type), 32'(ty));
    @(negedge clk);
    exp_inst++;
    chk({tag, "_icnt"}, 32'(inst_count), 32'(exp_inst));
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic expect_reject(input string tag);
    exp_err++;
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_ecnt"}, 32'(err_count), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(err), 32'd0);
    chk({tag, "_novld"}, 32'(out_valid), 32'd0);
    chk({tag, "_icnt"}, 32'(inst_count), 32'(exp_inst));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk("rst_inrdy", 32'(in_ready), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_word", instruction_word, 32'd0);
    chk("rst_type", 32'(out_type), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_icnt", 32'(inst_count), 32'd0);
    chk("rst_ecnt", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_inrdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    send(3'd0, 5'd5, 5'd21, 5'd4, 3'd0, 7'd0, 32'd0);
    expect_word("r", 32'h004A82B3, 3'd0);
    send(3'd1, 5'd7, 5'd19, 5'd0, 3'd0, 7'd0, 32'h209);
    expect_word("i", 32'h20998383, 3'd1);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    expect_word("b", 32'h00208463, 3'd3);
    send(3'd2, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, -32'sd4);
    expect_word("s", 32'hFE312E23, 3'd2);
    send(3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    expect_word("u", 32'h12345537, 3'd4);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_word("j", 32'h001000EF, 3'd5);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
    expect_word("i_min", 32'h80000083, 3'd1);

    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    expect_reject("b_odd");
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_reject("i_range");
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    expect_reject("type6");
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001);
    expect_reject("u_low");
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    expect_reject("j_odd");

    out_ready = 1'b0;
    drive(3'd0, 5'd5, 5'd21, 5'd4, 3'd0, 7'd0, 32'd0);
    chk("bp_rdy_a", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(3'd1, 5'd7, 5'd19, 5'd0, 3'd0, 7'd0, 32'h209);
    chk("bp_rdy_b", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    chk("bp_rdy_c", 32'(in_ready), 32'd0);
    chk("bp_vld", 32'(out_valid), 32'd1);
    chk("bp_word_a", instruction_word, 32'h004A82B3);
    @(negedge clk);
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_word", instruction_word, 32'h004A82B3);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_word_b", instruction_word, 32'h20998383);
    @(negedge clk);
    chk("bp_word_c", instruction_word, 32'h00208463);
    chk("bp_type_c", 32'(out_type), 32'd3);
    @(negedge clk);
    exp_inst += 3;
    chk("bp_drain", 32'(out_valid), 32'd0);
    chk("bp_icnt", 32'(inst_count), 32'(exp_inst));

    out_ready = 1'b0;
    drive(3'd0, 5'd5, 5'd21, 5'd4, 3'd0, 7'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(3'd1, 5'd7, 5'd19, 5'd0, 3'd0, 7'd0, 32'h209);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_inst = 0;
    exp_err = 0;
    chk("mr_vld", 32'(out_valid), 32'd0);
    chk("mr_word", instruction_word, 32'd0);
    chk("mr_inrdy", 32'(in_ready), 32'd0);
    chk("mr_icnt", 32'(inst_count), 32'd0);
    chk("mr_ecnt", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    expect_word("mr_b", 32'h00208463, 3'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
